// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the key-schedule slice: block geometry,
// word/block types, FSM state encoding and the two small byte/word helpers
// (xtime for the rcon progression, rotWord for the key-schedule rotation).
// No ports; imported with "import aes_pkg::*".
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NB = 4;
  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef logic [31:0]          word_t;
  typedef logic [AES_NB*32-1:0] block_t;

  typedef enum logic {
    IDLE,
    EMIT
  } kx_state_e;

  // Multiply by x in GF(2^8); reduction by the AES polynomial produces the
  // 8'h80 -> 8'h1b wrap in the round-constant sequence.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotation by one byte: {a,b,c,d} -> {b,c,d,a}.
  function automatic word_t rotWord(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes128_key_expand_if.sv
// -----------------------------------------------------------------------------
// aes128_key_expand_if
// Groups the command and round-key stream of the key-schedule engine.
//   start     command to begin an expansion (master -> slave)
//   key       128-bit cipher key, w0 in the top word (master -> slave)
//   rk_ready  downstream accepts the current round key (master -> slave)
//   rk_valid  rk/rk_idx hold a valid round key (slave -> master)
//   rk        round key, same word order as key (slave -> master)
//   rk_idx    round index 0..10 of rk (slave -> master)
//   busy      expansion in progress (slave -> master)
//   done      one-cycle pulse after the last key is taken (slave -> master)
// The slave modport is the engine; the master modport is its user.
// -----------------------------------------------------------------------------
interface aes128_key_expand_if;
  import aes_pkg::*;

  logic       start;
  block_t     key;
  logic       rk_ready;
  logic       rk_valid;
  block_t     rk;
  logic [3:0] rk_idx;
  logic       busy;
  logic       done;

  modport master (
    output start, key, rk_ready,
    input  rk_valid, rk, rk_idx, busy, done
  );

  modport slave (
    input  start, key, rk_ready,
    output rk_valid, rk, rk_idx, busy, done
  );

endinterface

// File: rtl/aes_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// Combinational SubWord: each of the four bytes of a 32-bit word is replaced
// by its forward AES S-box value.
//   word_i  input word
//   word_o  substituted word
// -----------------------------------------------------------------------------
module aes_subword
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // One independent table lookup per byte lane.
  for (genvar b = 0; b < 4; b++) begin : gLane
    assign word_o[b*8 +: 8] = SBOX[word_i[b*8 +: 8]];
  end

endmodule

// File: rtl/aes128_key_expand.sv
// -----------------------------------------------------------------------------
// aes128_key_expand
// Iterative AES-128 key schedule. On start the cipher key is emitted as round
// key 0; each accepted beat then produces the next round key one cycle later,
// so with rk_ready held high keys 0..10 stream back to back.
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   kx_if  slave side of aes128_key_expand_if (start/key in, rk stream out,
//          busy and done status)
// -----------------------------------------------------------------------------
module aes128_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input logic                 clk,
  input logic                 rst,
  aes128_key_expand_if.slave  kx_if
);

  kx_state_e  state_q;
  logic       rkValid_q;
  block_t     rk_q;
  logic [3:0] rkIdx_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] rcon_q;

  block_t     rk_d;
  logic [7:0] rcon_d;
  word_t      subIn;
  word_t      subOut;
  word_t      temp;
  word_t      prevWord [AES_NK];
  word_t      nextWord [AES_NK];

  // The S-box input depends only on the registered key, which keeps the
  // lookup off any loop through the combinational block below.
  assign subIn = rotWord(rk_q[31:0]);

  aes_subword uSubword (
    .word_i (subIn),
    .word_o (subOut)
  );

  // Next round key from the current one: the rotated, substituted last word
  // mixed with rcon feeds a chained XOR across the four words.
  always_comb begin
    rk_d = '0;
    temp = subOut ^ {rcon_q, 24'h000000};
    for (int i = 0; i < AES_NK; i++) begin
      prevWord[i] = rk_q[(AES_NK-1-i)*32 +: 32];
    end
    nextWord[0] = prevWord[0] ^ temp;
    for (int i = 1; i < AES_NK; i++) begin
      nextWord[i] = prevWord[i] ^ nextWord[i-1];
    end
    for (int i = 0; i < AES_NK; i++) begin
      rk_d[(AES_NK-1-i)*32 +: 32] = nextWord[i];
    end
    rcon_d = xtime(rcon_q);
  end

  // Control FSM and all registered outputs. A stalled beat leaves every
  // output untouched; accepting the last key returns to IDLE with a one-cycle
  // done pulse, and IDLE samples start again in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rkValid_q <= 1'b0;
      rk_q      <= '0;
      rkIdx_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rcon_q    <= 8'h01;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (kx_if.start) begin
            rk_q      <= kx_if.key;
            rkIdx_q   <= 4'd0;
            rcon_q    <= 8'h01;
            rkValid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= EMIT;
          end
        end
        EMIT: begin
          if (rkValid_q && kx_if.rk_ready) begin
            if (rkIdx_q == 4'(NUM_ROUNDS)) begin
              rkValid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              rk_q    <= rk_d;
              rkIdx_q <= rkIdx_q + 4'd1;
              rcon_q  <= rcon_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kx_if.rk_valid = rkValid_q;
  assign kx_if.rk       = rk_q;
  assign kx_if.rk_idx   = rkIdx_q;
  assign kx_if.busy     = busy_q;
  assign kx_if.done     = done_q;

endmodule

// File: tb/tb_aes128_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes128_key_expand
// Self-checking bench for aes128_key_expand. Round keys accepted from the
// stream are captured and compared against a table of known AES-128 key
// schedules; handshake, reset and start-handling corners are exercised with
// short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_aes128_key_expand;
  import aes_pkg::*;

  typedef struct {
    block_t key;
    int     idx;
    block_t rk;
  } vec_t;

  localparam block_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t ZERO_KEY = 128'h0;
  localparam block_t ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  vec_t       vecs [14];
  block_t     got [11];
  logic [3:0] gotIdx [11];
  int         beats;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  aes128_key_expand_if kx ();

  aes128_key_expand #(
    .NUM_ROUNDS (10)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .kx_if (kx)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Runs one expansion: starts it, optionally randomises rk_ready, captures
  // every accepted beat, checks that stalled beats hold still and that done
  // follows the eleventh acceptance. With holdStart the start line stays high
  // and key switches to lateKey once index 3 is showing.
  task automatic applyStimulus(input block_t k, input bit randReady,
                               input bit holdStart, input block_t lateKey);
    int         cycles;
    int         doneEarly;
    bit         stalled;
    block_t     prevRk;
    logic [3:0] prevIdx;
    kx.key      = k;
    kx.start    = 1'b1;
    kx.rk_ready = 1'b1;
    @(posedge clk); #1;
    if (!holdStart) kx.start = 1'b0;
    checkOutput("start latency valid", 128'(kx.rk_valid), 128'd1);
    checkOutput("busy after start", 128'(kx.busy), 128'd1);
    beats     = 0;
    cycles    = 0;
    doneEarly = 0;
    stalled   = 1'b0;
    prevRk    = '0;
    prevIdx   = 4'd0;
    while (beats < 11 && cycles < 400) begin
      if (randReady) kx.rk_ready = 1'($urandom_range(1, 0));
      if (stalled) begin
        checkOutput("stall valid hold", 128'(kx.rk_valid), 128'd1);
        checkOutput("stall rk hold", kx.rk, prevRk);
        checkOutput("stall idx hold", 128'(kx.rk_idx), 128'(prevIdx));
      end
      if (kx.done) doneEarly++;
      if (kx.rk_valid && kx.rk_ready) begin
        got[beats]    = kx.rk;
        gotIdx[beats] = kx.rk_idx;
        beats++;
      end
      stalled = kx.rk_valid && !kx.rk_ready;
      prevRk  = kx.rk;
      prevIdx = kx.rk_idx;
      if (holdStart && kx.rk_idx == 4'd3) kx.key = lateKey;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("accepted beats", 128'(beats), 128'd11);
    checkOutput("done after last beat", 128'(kx.done), 128'd1);
    checkOutput("valid low at done", 128'(kx.rk_valid), 128'd0);
    checkOutput("busy low at done", 128'(kx.busy), 128'd0);
    checkOutput("no early done", 128'(doneEarly), 128'd0);
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("beat %0d index", i), 128'(gotIdx[i]), 128'(i));
    end
    if (!holdStart) begin
      @(posedge clk); #1;
      checkOutput("done single pulse", 128'(kx.done), 128'd0);
    end
  endtask

  // Compares captured beats against every table entry for the given key.
  task automatic checkTable(input block_t k, input string tag);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].key == k) begin
        checkOutput($sformatf("%s rk idx%0d", tag, vecs[i].idx),
                    got[vecs[i].idx], vecs[i].rk);
      end
    end
  endtask

  // Main sequence: reset values, full-rate expansions, backpressure, start
  // held through an expansion, and reset in the middle of a stream.
  initial begin
    int  n;
    bit  sawActivity;

    vecs[0]  = '{FIPS_KEY, 0,  FIPS_KEY};
    vecs[1]  = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{FIPS_KEY, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{FIPS_KEY, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{FIPS_KEY, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{FIPS_KEY, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{FIPS_KEY, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{FIPS_KEY, 8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[11] = '{ZERO_KEY, 0,  128'h0};
    vecs[12] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363};
    vecs[13] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst         = 1'b1;
    kx.start    = 1'b0;
    kx.key      = '0;
    kx.rk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset rk_valid", 128'(kx.rk_valid), 128'd0);
    checkOutput("reset rk", kx.rk, 128'd0);
    checkOutput("reset rk_idx", 128'(kx.rk_idx), 128'd0);
    checkOutput("reset busy", 128'(kx.busy), 128'd0);
    checkOutput("reset done", 128'(kx.done), 128'd0);
    sawActivity = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (kx.rk_valid || kx.done || kx.busy) sawActivity = 1'b1;
    end
    checkOutput("idle quiet", 128'(sawActivity), 128'd0);

    applyStimulus(FIPS_KEY, 1'b0, 1'b0, '0);
    checkTable(FIPS_KEY, "fips");
    checkOutput("rk retained in idle", kx.rk, vecs[10].rk);
    checkOutput("idx retained in idle", 128'(kx.rk_idx), 128'd10);

    applyStimulus(ZERO_KEY, 1'b0, 1'b0, '0);
    checkTable(ZERO_KEY, "zero");

    applyStimulus(FIPS_KEY, 1'b1, 1'b0, '0);
    checkTable(FIPS_KEY, "backpressure");

    applyStimulus(FIPS_KEY, 1'b0, 1'b1, ALT_KEY);
    checkTable(FIPS_KEY, "held start");
    @(posedge clk); #1;
    checkOutput("restart valid", 128'(kx.rk_valid), 128'd1);
    checkOutput("restart idx", 128'(kx.rk_idx), 128'd0);
    checkOutput("restart rk", kx.rk, ALT_KEY);
    checkOutput("restart done low", 128'(kx.done), 128'd0);
    kx.start = 1'b0;

    kx.rk_ready = 1'b1;
    n = 0;
    while (kx.rk_idx != 4'd5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reached idx 5", 128'(kx.rk_idx), 128'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort rk_valid", 128'(kx.rk_valid), 128'd0);
    checkOutput("abort busy", 128'(kx.busy), 128'd0);
    checkOutput("abort done", 128'(kx.done), 128'd0);
    checkOutput("abort rk", kx.rk, 128'd0);
    checkOutput("abort rk_idx", 128'(kx.rk_idx), 128'd0);
    sawActivity = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (kx.rk_valid || kx.done) sawActivity = 1'b1;
    end
    checkOutput("quiet after abort", 128'(sawActivity), 128'd0);

    applyStimulus(FIPS_KEY, 1'b0, 1'b0, '0);
    checkTable(FIPS_KEY, "after abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
